// File: rtl/dht11_pkg.sv
// DHT11 sensor emulator: shared state encoding, frame size,
// default bus timing and checksum helper.
package dht11_pkg;

    localparam int FRAME_BITS       = 40;

    localparam int CLK_PER_US_DEF   = 100;
    localparam int START_MIN_US_DEF = 16000;
    localparam int START_MAX_US_DEF = 30000;
    localparam int RESP_DLY_US_DEF  = 20;
    localparam int ACK_US_DEF       = 80;
    localparam int BIT_LOW_US_DEF   = 50;
    localparam int BIT0_HIGH_US_DEF = 26;
    localparam int BIT1_HIGH_US_DEF = 70;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_STUCK,
        ST_RESP_DLY,
        ST_ACK_LOW,
        ST_ACK_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } state_e;

    function automatic logic [7:0] dht_sum(input logic [15:0] h,
                                           input logic [15:0] t);
        return h[15:8] + h[7:0] + t[15:8] + t[7:0];
    endfunction

endpackage

// File: rtl/dht11_sensor_emu_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US enabled
// cycles; clear restarts the count so a phase starts on a us boundary.
module us_tick_gen #(
    parameter int CLK_PER_US = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);
    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick_o = enable_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor-side responder: accepts a host start pulse and answers
// with ACK plus a 40-bit {hmd, tmp, sum} frame, open-drain.
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US   = CLK_PER_US_DEF,
    parameter int START_MIN_US = START_MIN_US_DEF,
    parameter int START_MAX_US = START_MAX_US_DEF,
    parameter int RESP_DLY_US  = RESP_DLY_US_DEF,
    parameter int ACK_US       = ACK_US_DEF,
    parameter int BIT_LOW_US   = BIT_LOW_US_DEF,
    parameter int BIT0_HIGH_US = BIT0_HIGH_US_DEF,
    parameter int BIT1_HIGH_US = BIT1_HIGH_US_DEF
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    inout  wire         dht_io,
    input  logic        i_enable,
    input  logic [15:0] i_hmd,
    input  logic [15:0] i_tmp,
    input  logic        i_bad_sum,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_err
);
    localparam int UW = $clog2(START_MAX_US + 1);

    state_e                state_q;
    logic [1:0]            sync_q;
    logic                  line_q;
    logic [UW-1:0]         us_q;
    logic [5:0]            idx_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic                  drive_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic          line_s;
    logic          fall;
    logic          tick;
    logic          tick_en;
    logic          clear;
    logic          phase_end;
    logic [UW-1:0] lim;
    logic [7:0]    sum;

    assign line_s = sync_q[1];
    assign fall   = line_q & ~line_s;
    assign sum    = dht_sum(i_hmd, i_tmp);

    assign dht_io       = drive_q ? 1'b0 : 1'bz;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_err        = err_q;

    // Length of the current timed phase in us; START_LOW uses the stuck limit.
    always_comb begin
        lim = UW'(START_MAX_US);
        unique case (state_q)
            ST_RESP_DLY:             lim = UW'(RESP_DLY_US);
            ST_ACK_LOW, ST_ACK_HIGH: lim = UW'(ACK_US);
            ST_BIT_LOW, ST_END_LOW:  lim = UW'(BIT_LOW_US);
            ST_BIT_HIGH:             lim = frame_q[idx_q] ? UW'(BIT1_HIGH_US)
                                                          : UW'(BIT0_HIGH_US);
            default:                 ;
        endcase
    end

    assign tick_en   = !(state_q inside {ST_IDLE, ST_STUCK});
    assign phase_end = tick && (us_q == lim - UW'(1));
    assign clear     = (state_q == ST_IDLE) || (state_q == ST_STUCK) ||
                       ((state_q == ST_START_LOW) && line_s) || phase_end;

    us_tick_gen #(
        .CLK_PER_US(CLK_PER_US)
    ) u_tick (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .clear_i (clear),
        .enable_i(tick_en),
        .tick_o  (tick)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            sync_q  <= 2'b11;
            line_q  <= 1'b1;
            us_q    <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], dht_io};
            line_q <= line_s;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (tick) begin
                us_q <= us_q + UW'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (i_enable && fall) begin
                        us_q    <= '0;
                        state_q <= ST_START_LOW;
                    end
                end
                ST_START_LOW: begin
                    if (line_s) begin
                        us_q <= '0;
                        if (us_q < UW'(START_MIN_US)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            frame_q <= {i_hmd, i_tmp, i_bad_sum ? ~sum : sum};
                            busy_q  <= 1'b1;
                            state_q <= ST_RESP_DLY;
                        end
                    end else if (phase_end) begin
                        us_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_STUCK;
                    end
                end
                ST_STUCK: begin
                    if (line_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RESP_DLY: begin
                    if (phase_end) begin
                        us_q    <= '0;
                        drive_q <= 1'b1;
                        state_q <= ST_ACK_LOW;
                    end
                end
                ST_ACK_LOW: begin
                    if (phase_end) begin
                        us_q    <= '0;
                        drive_q <= 1'b0;
                        state_q <= ST_ACK_HIGH;
                    end
                end
                ST_ACK_HIGH: begin
                    if (phase_end) begin
                        us_q    <= '0;
                        drive_q <= 1'b1;
                        idx_q   <= 6'(FRAME_BITS - 1);
                        state_q <= ST_BIT_LOW;
                    end
                end
                ST_BIT_LOW: begin
                    if (phase_end) begin
                        us_q    <= '0;
                        drive_q <= 1'b0;
                        state_q <= ST_BIT_HIGH;
                    end
                end
                ST_BIT_HIGH: begin
                    if (phase_end) begin
                        us_q    <= '0;
                        drive_q <= 1'b1;
                        if (idx_q == 6'd0) begin
                            state_q <= ST_END_LOW;
                        end else begin
                            idx_q   <= idx_q - 6'd1;
                            state_q <= ST_BIT_LOW;
                        end
                    end
                end
                ST_END_LOW: begin
                    if (phase_end) begin
                        us_q    <= '0;
                        drive_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Bench for dht11_sensor_emu: host pulses push expected line segments
// into a queue; a negedge monitor measures the bus and pops/compares.
module tb_dht11_sensor_emu;

    localparam int CLK    = 2;
    localparam int SMIN   = 16;
    localparam int SMAX   = 30;
    localparam int RESP   = 2;
    localparam int ACK    = 8;
    localparam int BLOW   = 5;
    localparam int B0H    = 3;
    localparam int B1H    = 7;

    localparam int RESP_C = RESP * CLK;
    localparam int ACK_C  = ACK * CLK;
    localparam int BLOW_C = BLOW * CLK;
    localparam int B0_C   = B0H * CLK;
    localparam int B1_C   = B1H * CLK;
    localparam int MAX_C  = SMAX * CLK;

    typedef enum int {EV_DLY, EV_LOW, EV_HIGH, EV_DONE, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       val;
    } ev_t;

    logic        clk = 1'b0;
    logic        PRESETn;
    logic        host_low;
    logic        i_enable;
    logic [15:0] i_hmd;
    logic [15:0] i_tmp;
    logic        i_bad_sum;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_err;
    wire         dht_line;

    pullup (dht_line);
    assign dht_line = host_low ? 1'b0 : 1'bz;

    dht11_sensor_emu #(
        .CLK_PER_US  (CLK),
        .START_MIN_US(SMIN),
        .START_MAX_US(SMAX),
        .RESP_DLY_US (RESP),
        .ACK_US      (ACK),
        .BIT_LOW_US  (BLOW),
        .BIT0_HIGH_US(B0H),
        .BIT1_HIGH_US(B1H)
    ) dut (
        .PCLK        (clk),
        .PRESETn     (PRESETn),
        .dht_io      (dht_line),
        .i_enable    (i_enable),
        .i_hmd       (i_hmd),
        .i_tmp       (i_tmp),
        .i_bad_sum   (i_bad_sum),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  host_edge_cyc = 0;
    ev_t exp_q[$];

    logic mon_on = 1'b0;
    logic prev_line;
    logic low_by_host;
    logic after_rel;
    int   edge_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic exp_push(ev_kind_e k, int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic emit(ev_kind_e k, int v);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s/%0d required none",
                     k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                n_fail++;
                $display("FAIL event: got %s/%0d required %s/%0d",
                         k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    // Release is seen one cycle before the first sampling edge, hence +3.
    task automatic push_frame(logic [15:0] h, logic [15:0] t, logic [7:0] s);
        logic [39:0] f;
        f = {h, t, s};
        exp_push(EV_DLY, RESP_C + 3);
        exp_push(EV_LOW, ACK_C);
        exp_push(EV_HIGH, ACK_C);
        for (int i = 39; i >= 0; i--) begin
            exp_push(EV_LOW, BLOW_C);
            exp_push(EV_HIGH, f[i] ? B1_C : B0_C);
        end
        exp_push(EV_LOW, BLOW_C);
        exp_push(EV_DONE, 0);
    endtask

    task automatic host_pulse(int low_cyc);
        @(posedge clk);
        #1;
        host_low      = 1'b1;
        host_edge_cyc = cyc;
        repeat (low_cyc) @(posedge clk);
        #1;
        host_low      = 1'b0;
        host_edge_cyc = cyc;
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d events pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (dht_line !== prev_line) begin
                if (dht_line == 1'b0) begin
                    if (host_low) begin
                        low_by_host = 1'b1;
                    end else begin
                        low_by_host = 1'b0;
                        emit(after_rel ? EV_DLY : EV_HIGH, cyc - edge_cyc);
                        after_rel = 1'b0;
                    end
                end else begin
                    if (low_by_host) after_rel = 1'b1;
                    else emit(EV_LOW, cyc - edge_cyc);
                    low_by_host = 1'b0;
                end
                edge_cyc  = cyc;
                prev_line = dht_line;
            end
            if (o_frame_done) emit(EV_DONE, cyc - edge_cyc);
            if (o_err) emit(EV_ERR, cyc - host_edge_cyc);
        end else begin
            prev_line   = dht_line;
            low_by_host = 1'b0;
            after_rel   = 1'b0;
            edge_cyc    = cyc;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int offs[2];
        offs[0] = 51;
        offs[1] = 20;
        PRESETn   = 1'b0;
        host_low  = 1'b0;
        i_enable  = 1'b1;
        i_hmd     = 16'h3A00;
        i_tmp     = 16'h1905;
        i_bad_sum = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_line", dht_line, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_frame_done, 1'b0);
        check("rst_err", o_err, 1'b0);
        PRESETn = 1'b1;
        repeat (3) @(posedge clk);
        mon_on = 1'b1;

        // nominal frame, sum 3A+00+19+05 = 58
        push_frame(16'h3A00, 16'h1905, 8'h58);
        host_pulse(18 * CLK);
        repeat (10) @(posedge clk);
        #1;
        check("busy_frame", o_busy, 1'b1);
        drain("frame_nominal", 3000);
        check("busy_after", o_busy, 1'b0);

        // short start
        exp_push(EV_ERR, 3);
        host_pulse(5 * CLK);
        drain("short_start", 200);
        check("busy_short", o_busy, 1'b0);

        // just under the minimum once discretised to us ticks
        exp_push(EV_ERR, 3);
        host_pulse(16 * CLK);
        drain("min_minus", 200);

        // just over the minimum; sum 01+02+FF+FF = 01
        i_hmd = 16'h0102;
        i_tmp = 16'hFFFF;
        push_frame(16'h0102, 16'hFFFF, 8'h01);
        host_pulse(16 * CLK + 2);
        drain("min_plus", 3000);

        // stuck bus, then recovery
        i_hmd = 16'h3A00;
        i_tmp = 16'h1905;
        exp_push(EV_ERR, MAX_C + 3);
        host_pulse(35 * CLK);
        drain("stuck", 200);
        check("busy_stuck", o_busy, 1'b0);
        push_frame(16'h3A00, 16'h1905, 8'h58);
        host_pulse(18 * CLK);
        drain("after_stuck", 3000);

        // inverted checksum, inputs changed mid-frame
        i_bad_sum = 1'b1;
        push_frame(16'h3A00, 16'h1905, 8'hA7);
        host_pulse(18 * CLK);
        repeat (20) @(posedge clk);
        #1;
        i_hmd     = 16'hFFFF;
        i_bad_sum = 1'b0;
        drain("bad_sum", 3000);
        i_hmd = 16'h3A00;

        // disabled: start ignored
        i_enable = 1'b0;
        host_pulse(18 * CLK);
        repeat (10) @(posedge clk);
        #1;
        check("dis_busy", o_busy, 1'b0);
        repeat (400) @(posedge clk);
        #1;
        check("dis_quiet", exp_q.size(), 0);
        i_enable = 1'b1;

        // async reset mid-frame: BIT_HIGH, then ACK_LOW
        for (int k = 0; k < 2; k++) begin
            mon_on = 1'b0;
            host_pulse(18 * CLK);
            repeat (offs[k]) @(posedge clk);
            #1;
            check("pre_rst_busy", o_busy, 1'b1);
            PRESETn = 1'b0;
            #1;
            check("mid_rst_line", dht_line, 1'b1);
            check("mid_rst_busy", o_busy, 1'b0);
            check("mid_rst_done", o_frame_done, 1'b0);
            check("mid_rst_err", o_err, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            PRESETn = 1'b1;
            repeat (3) @(posedge clk);
            mon_on = 1'b1;
        end

        push_frame(16'h3A00, 16'h1905, 8'h58);
        host_pulse(18 * CLK);
        drain("after_reset", 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
